avmm_burst_slave_mem: RTL

AVMM_BURST_SLAVE_MEM -- requirements
Module: avmm_burst_slave_mem

---
 rtl/avmm_burst_slave_pkg.sv | 28 ++
 rtl/avmm_rd_cmd_fifo.sv | 57 +++++
 rtl/avmm_burst_slave_mem.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/avmm_burst_slave_pkg.sv
// Shared defaults, FSM state type and read-command entry for the burst slave memory.
package avmm_burst_slave_pkg;

    localparam int ADDR_W_DEF        = 12;
    localparam int DATA_W_DEF        = 32;
    localparam int BURST_W_DEF       = 4;
    localparam int MAX_BURST_DEF     = 8;
    localparam int RD_FIFO_DEPTH_DEF = 4;

    // Queue entries are sized from the defaults; widen these for a larger ADDR_W/BURST_W.
    localparam int RD_WORD_W = ADDR_W_DEF - 2;
    localparam int RD_LEN_W  = BURST_W_DEF;

    typedef enum logic {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic [RD_WORD_W-1:0] word;
        logic [RD_LEN_W-1:0]  len;
    } rd_cmd_t;

    function automatic logic burst_legal(input int unsigned bc, input int unsigned max_burst);
        return (bc != 0) && (bc <= max_burst);
    endfunction

endpackage

// File: rtl/avmm_rd_cmd_fifo.sv
// Show-ahead synchronous FIFO holding accepted read commands.
module avmm_rd_cmd_fifo
    import avmm_burst_slave_pkg::*;
#(
    parameter int DEPTH = RD_FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  rd_cmd_t                      push_data,
    input  logic                         pop,
    output rd_cmd_t                      pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rd_cmd_t          slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/avmm_burst_slave_mem.sv
// Avalon-MM burst-capable slave memory with a queued, pipelined read engine.
//   state    | meaning
//   IDLE     | waiting for the first beat of a write (or single-beat write)
//   WR_BURST | collecting the remaining beats of a multi-beat write
module avmm_burst_slave_mem
    import avmm_burst_slave_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int BURST_W       = BURST_W_DEF,
    parameter int MAX_BURST     = MAX_BURST_DEF,
    parameter int RD_FIFO_DEPTH = RD_FIFO_DEPTH_DEF
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic [BURST_W-1:0]    avs_burstcount,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [1:0]            err_sticky
);

    localparam int WORD_W      = ADDR_W - 2;
    localparam int NUM_SYMBOLS = DATA_W / 8;
    localparam int MEM_WORDS   = 2 ** WORD_W;

    logic [DATA_W-1:0]  mem [MEM_WORDS];

    wr_state_t          state;
    logic [WORD_W-1:0]  wr_addr;
    logic [BURST_W-1:0] wr_left;

    logic [WORD_W-1:0]  cmd_word;
    logic [BURST_W-1:0] cmd_len;
    logic               bc_legal;
    logic               wr_acc;
    logic               rd_acc;
    logic [WORD_W-1:0]  wr_word;
    logic               unused_addr_lsb;

    rd_cmd_t            q_push_cmd;
    rd_cmd_t            q_head;
    logic               q_full;
    logic               q_empty;
    logic               q_pop;
    logic [$clog2(RD_FIFO_DEPTH+1)-1:0] unused_q_count;

    logic               rd_active;
    logic [WORD_W-1:0]  rd_addr;
    logic [BURST_W-1:0] rd_left;
    logic [WORD_W-1:0]  head_word;
    logic [BURST_W-1:0] head_len;
    logic               issue;
    logic [WORD_W-1:0]  issue_addr;

    assign cmd_word        = avs_address[ADDR_W-1:2];
    assign unused_addr_lsb = ^avs_address[1:0];
    assign bc_legal        = burst_legal(32'(avs_burstcount), MAX_BURST);
    assign cmd_len         = bc_legal ? avs_burstcount : BURST_W'(1);

    always_comb begin
        avs_waitrequest = 1'b0;
        if (reset_reset)
            avs_waitrequest = 1'b1;
        else if (avs_write && (!q_empty || rd_active))
            avs_waitrequest = 1'b1;
        else if (avs_read && (q_full || state == WR_BURST))
            avs_waitrequest = 1'b1;
    end

    // A simultaneous read and write only ever honours the write.
    assign wr_acc  = avs_write && !avs_waitrequest;
    assign rd_acc  = avs_read && !avs_write && !avs_waitrequest;
    assign wr_word = (state == IDLE) ? cmd_word : wr_addr;

    always_ff @(posedge clk_clk) begin
        if (wr_acc) begin
            for (int b = 0; b < NUM_SYMBOLS; b++) begin
                if (avs_byteenable[b]) mem[wr_word][b*8 +: 8] <= avs_writedata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state   <= IDLE;
            wr_addr <= '0;
            wr_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_acc && cmd_len != BURST_W'(1)) begin
                        state   <= WR_BURST;
                        wr_addr <= cmd_word + 1'b1;
                        wr_left <= cmd_len - 1'b1;
                    end
                end
                WR_BURST: begin
                    if (wr_acc) begin
                        wr_addr <= wr_addr + 1'b1;
                        wr_left <= wr_left - 1'b1;
                        if (wr_left == BURST_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        q_push_cmd.word = RD_WORD_W'(cmd_word);
        q_push_cmd.len  = RD_LEN_W'(cmd_len);
    end

    avmm_rd_cmd_fifo #(
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_cmd_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .push      (rd_acc),
        .push_data (q_push_cmd),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (unused_q_count)
    );

    // The head entry stays queued until its last beat issues, so it still counts toward full.
    assign head_word  = WORD_W'(q_head.word);
    assign head_len   = BURST_W'(q_head.len);
    assign issue      = rd_active || !q_empty;
    assign issue_addr = rd_active ? rd_addr : head_word;
    assign q_pop      = rd_active ? (rd_left == BURST_W'(1))
                                  : (!q_empty && head_len == BURST_W'(1));

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rd_active         <= 1'b0;
            rd_addr           <= '0;
            rd_left           <= '0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            avs_readdatavalid <= issue;
            if (issue) avs_readdata <= mem[issue_addr];
            if (rd_active) begin
                rd_addr <= rd_addr + 1'b1;
                rd_left <= rd_left - 1'b1;
                if (rd_left == BURST_W'(1)) rd_active <= 1'b0;
            end else if (!q_empty && head_len != BURST_W'(1)) begin
                rd_active <= 1'b1;
                rd_addr   <= head_word + 1'b1;
                rd_left   <= head_len - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            err_sticky <= 2'b00;
        end else begin
            if (((wr_acc && state == IDLE) || rd_acc) && !bc_legal) err_sticky[0] <= 1'b1;
            if (avs_read && avs_write) err_sticky[1] <= 1'b1;
        end
    end

endmodule
